matrix: RTL and testbench

MATRIX -- requirements
Module: matrix

---
 rtl/matrix.sv | 105 ++++++++++
 tb/tb_matrix.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix.sv
// rtl/matrix.sv - 3x3 window line-buffer matrix: two cascaded line delays plus window taps
//
// Purpose:
//   Accepts a raster-order pixel stream and presents one column of a 3-row
//   sliding window per accepted pixel, plus the window centre pixel.
//
// Ports:
//   clk       in   1       sole clock, rising edge
//   rst_n     in   1       asynchronous active-low reset
//   datain    in   DATA_W  incoming pixel, raster order
//   valid_in  in   1       1 = datain is accepted this cycle
//   dout_2    out  DATA_W  current-row tap (datain delayed one cycle)
//   dout_1    out  DATA_W  same column, one line earlier
//   dout_0    out  DATA_W  same column, two lines earlier
//   dout      out  DATA_W  window centre (middle row, previous column)
//   can_cout  out  1       1 = taps form a valid window column this cycle

module matrix #(
  parameter int DATA_W = 10,
  parameter int LINE_W = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] datain,
  input  logic              valid_in,
  output logic [DATA_W-1:0] dout_2,
  output logic [DATA_W-1:0] dout_1,
  output logic [DATA_W-1:0] dout_0,
  output logic [DATA_W-1:0] dout,
  output logic              can_cout
);

  localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam logic [1:0] ROW_FULL = 2'd2;

  // Column counter doubles as the shared read/write pointer of both line
  // buffers: a location is rewritten exactly LINE_W accepted pixels after it
  // was last written, which gives the one-line delay without extra pointers.
  logic [COL_W-1:0]  col;
  logic [1:0]        row;

  logic [DATA_W-1:0] lb1_mem [LINE_W];
  logic [DATA_W-1:0] lb2_mem [LINE_W];
  logic [DATA_W-1:0] lb1_q;
  logic [DATA_W-1:0] lb2_q;

  // Old contents at the current column, read before this cycle's write.
  assign lb1_q = lb1_mem[col];
  assign lb2_q = lb2_mem[col];

  // Line storage is deliberately not reset; stale contents are masked by
  // can_cout until two full lines have been accepted since reset.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1_mem[col] <= datain;
      lb2_mem[col] <= lb1_q;
    end
  end

  // Column wraps every LINE_W accepted pixels; row saturates at 2, meaning
  // both line buffers now hold real pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row != ROW_FULL) begin
          row <= row + 2'd1;
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Taps hold on idle cycles; dout takes the middle-row tap from the
  // previous accepted update, i.e. the centre column of the 3x3 window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_2 <= '0;
      dout_1 <= '0;
      dout_0 <= '0;
      dout   <= '0;
    end else if (valid_in) begin
      dout_2 <= datain;
      dout_1 <= lb1_q;
      dout_0 <= lb2_q;
      dout   <= dout_1;
    end
  end

  // Row value before this cycle's update decides validity, so the first
  // valid column follows pixel index 2*LINE_W. Idle cycles force 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      can_cout <= 1'b0;
    end else begin
      can_cout <= valid_in && (row == ROW_FULL);
    end
  end

endmodule

// File: tb/tb_matrix.sv
// tb/tb_matrix.sv - self-checking bench for matrix with a pixel-history reference model

module tb_matrix;

  localparam int DW = 10;
  localparam int LW = 480;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] datain;
  logic          valid_in;
  logic [DW-1:0] dout_2;
  logic [DW-1:0] dout_1;
  logic [DW-1:0] dout_0;
  logic [DW-1:0] dout;
  logic          can_cout;

  int vecs;
  int miss;

  // Reference model: every accepted pixel since reset, in order.
  logic [DW-1:0] hist [$];
  logic [DW-1:0] e_d2, e_d1, e_d0, e_dout;
  logic          e_can;
  bit            known;

  matrix #(.DATA_W(DW), .LINE_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .datain   (datain),
    .valid_in (valid_in),
    .dout_2   (dout_2),
    .dout_1   (dout_1),
    .dout_0   (dout_0),
    .dout     (dout),
    .can_cout (can_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    hist.delete();
    e_d2 = '0; e_d1 = '0; e_d0 = '0; e_dout = '0;
    e_can = 1'b0;
    known = 1'b1;
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the
  // rising edge, and advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d);
    int idx;
    @(negedge clk);
    valid_in = v;
    datain   = d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_clear();
    end else if (v) begin
      hist.push_back(d);
      idx   = hist.size() - 1;
      e_d2  = d;
      e_can = (idx >= 2 * LW);
      if (e_can) begin
        e_d1   = hist[idx - LW];
        e_d0   = hist[idx - 2 * LW];
        e_dout = hist[idx - 1 - LW];
      end
      known = e_can;
    end else begin
      e_can = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom));
      vecs++;
      if ({dout_2, dout_1, dout_0, dout} !== '0 || can_cout !== 1'b0) begin
        miss++;
        $display("FAIL reset cyc %0d: got d2=%0d d1=%0d d0=%0d dout=%0d can=%0b, want all 0",
                 i, dout_2, dout_1, dout_0, dout, can_cout);
      end
    end
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    model_clear();
  endtask

  task automatic test_fill();
    logic [DW-1:0] x, xm1;
    for (int i = 0; i < 3 * LW + 100; i++) begin
      x   = DW'(i % LW);
      xm1 = (x == 0) ? DW'(LW - 1) : x - 1'b1;
      cycle(1'b1, x);
      vecs++;
      if (can_cout !== (i >= 2 * LW)) begin
        miss++;
        $display("FAIL fill_can idx %0d: got %0b want %0b", i, can_cout, (i >= 2 * LW));
      end
      vecs++;
      if (dout_2 !== e_d2) begin
        miss++;
        $display("FAIL fill_d2 idx %0d: got %0d want %0d", i, dout_2, e_d2);
      end
      if (i >= 2 * LW) begin
        vecs++;
        if (dout_0 !== x || dout_1 !== x || dout_2 !== x || dout !== xm1) begin
          miss++;
          $display("FAIL align idx %0d: got d0=%0d d1=%0d d2=%0d dout=%0d want x=%0d dout=%0d",
                   i, dout_0, dout_1, dout_2, dout, x, xm1);
        end
      end
    end
  endtask

  task automatic test_rows();
    logic [DW-1:0] v2, v1, v0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < LW; c++) begin
        v2 = DW'(k * 1000 + c);
        v1 = DW'((k - 1) * 1000 + c);
        v0 = DW'((k - 2) * 1000 + c);
        cycle(1'b1, v2);
        vecs++;
        if (can_cout !== (k >= 2)) begin
          miss++;
          $display("FAIL rows_can k=%0d c=%0d: got %0b want %0b", k, c, can_cout, (k >= 2));
        end
        if (k >= 2) begin
          vecs++;
          if (dout_2 !== v2 || dout_1 !== v1 || dout_0 !== v0 || dout !== e_dout) begin
            miss++;
            $display("FAIL rows k=%0d c=%0d: got %0d/%0d/%0d dout=%0d want %0d/%0d/%0d dout=%0d",
                     k, c, dout_2, dout_1, dout_0, dout, v2, v1, v0, e_dout);
          end
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] v2, v1, v0;
    int idle;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < LW; c++) begin
        idle = 0;
        while (idle < 4 && $urandom_range(0, 2) == 0) begin
          idle++;
          cycle(1'b0, DW'($urandom));
          vecs++;
          if (can_cout !== 1'b0 || dout_2 !== e_d2) begin
            miss++;
            $display("FAIL gap_idle k=%0d c=%0d: got can=%0b d2=%0d want 0/%0d",
                     k, c, can_cout, dout_2, e_d2);
          end
          if (known) begin
            vecs++;
            if (dout_1 !== e_d1 || dout_0 !== e_d0 || dout !== e_dout) begin
              miss++;
              $display("FAIL gap_hold k=%0d c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                       k, c, dout_1, dout_0, dout, e_d1, e_d0, e_dout);
            end
          end
        end
        v2 = DW'(k * 1000 + c);
        v1 = DW'((k - 1) * 1000 + c);
        v0 = DW'((k - 2) * 1000 + c);
        cycle(1'b1, v2);
        vecs++;
        if (can_cout !== (k >= 2)) begin
          miss++;
          $display("FAIL gap_can k=%0d c=%0d: got %0b want %0b", k, c, can_cout, (k >= 2));
        end
        if (k >= 2) begin
          vecs++;
          if (dout_2 !== v2 || dout_1 !== v1 || dout_0 !== v0 || dout !== e_dout) begin
            miss++;
            $display("FAIL gap_rows k=%0d c=%0d: got %0d/%0d/%0d dout=%0d want %0d/%0d/%0d dout=%0d",
                     k, c, dout_2, dout_1, dout_0, dout, v2, v1, v0, e_dout);
          end
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    for (int i = 0; i < 700; i++) begin
      cycle(1'b1, DW'(i % LW));
      vecs++;
      if (can_cout !== 1'b0 || dout_2 !== e_d2) begin
        miss++;
        $display("FAIL mid_pre idx %0d: got can=%0b d2=%0d want 0/%0d", i, can_cout, dout_2, e_d2);
      end
    end
    // Assert reset between clock edges: outputs must clear without a clock.
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    model_clear();
    vecs++;
    if ({dout_2, dout_1, dout_0, dout} !== '0 || can_cout !== 1'b0) begin
      miss++;
      $display("FAIL mid_async: got d2=%0d d1=%0d d0=%0d dout=%0d can=%0b want all 0",
               dout_2, dout_1, dout_0, dout, can_cout);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, DW'($urandom));
      vecs++;
      if ({dout_2, dout_1, dout_0, dout} !== '0 || can_cout !== 1'b0) begin
        miss++;
        $display("FAIL mid_held cyc %0d: got nonzero outputs can=%0b d2=%0d", i, can_cout, dout_2);
      end
    end
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    for (int i = 0; i < 2 * LW + 140; i++) begin
      cycle(1'b1, DW'((700 + i) % LW));
      vecs++;
      if (can_cout !== (i >= 2 * LW) || dout_2 !== e_d2) begin
        miss++;
        $display("FAIL mid_refill idx %0d: got can=%0b d2=%0d want %0b/%0d",
                 i, can_cout, dout_2, (i >= 2 * LW), e_d2);
      end
      if (known) begin
        vecs++;
        if (dout_1 !== e_d1 || dout_0 !== e_d0 || dout !== e_dout) begin
          miss++;
          $display("FAIL mid_taps idx %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                   i, dout_1, dout_0, dout, e_d1, e_d0, e_dout);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom));
      vecs++;
      if (can_cout !== e_can || dout_2 !== e_d2) begin
        miss++;
        $display("FAIL rand cyc %0d: got can=%0b d2=%0d want %0b/%0d",
                 i, can_cout, dout_2, e_can, e_d2);
      end
      if (known) begin
        vecs++;
        if (dout_1 !== e_d1 || dout_0 !== e_d0 || dout !== e_dout) begin
          miss++;
          $display("FAIL rand_taps cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                   i, dout_1, dout_0, dout, e_d1, e_d0, e_dout);
        end
      end
    end
  endtask

  initial begin
    vecs     = 0;
    miss     = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    datain   = '0;
    model_clear();
    test_reset();
    test_fill();
    test_rows();
    test_gaps();
    test_midframe_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
